// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with saturating ADD/SUB/ABS,
// shifts, rotates, signed compare and a sticky overflow flag.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int SHW    = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              sat_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_overflow,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_NOR  = 4'h5,
    OP_SRL  = 4'h6,
    OP_ROTR = 4'h7,
    OP_NOT  = 4'h8,
    OP_NAND = 4'h9,
    OP_MAX  = 4'hA,
    OP_MIN  = 4'hB,
    OP_ABS  = 4'hC,
    OP_SLTS = 4'hD,
    OP_SLL  = 4'hE,
    OP_ROTL = 4'hF
  } op_e;

  localparam logic [DATA_W-1:0] MAXV =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINV =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DW_V = DATA_W'(DATA_W);

  // S1 state
  logic              s1_v_q;
  op_e               op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              sat_q;

  // S2 state
  logic              s2_v_q;
  logic [DATA_W-1:0] res_q;
  logic              ovf_q;
  logic              sticky_q;

  logic              s2_adv;
  logic [DATA_W-1:0] res_d;
  logic              ovf_d;
  logic              sticky_d;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] neg;
  logic              add_ovf;
  logic              sub_ovf;
  logic              lt;
  logic              gt;
  logic              big_sh;
  logic [SHW-1:0]    amt;
  logic [DATA_W-1:0] rotr;
  logic [DATA_W-1:0] rotl;

  assign s2_adv   = !s2_v_q || out_ready;
  assign in_ready = rst_n && (!s1_v_q || s2_adv);

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign neg  = '0 - a_q;

  assign add_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1])
                && (sum[DATA_W-1] != a_q[DATA_W-1]);
  assign sub_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1])
                && (diff[DATA_W-1] != a_q[DATA_W-1]);

  assign lt = $signed(a_q) < $signed(b_q);
  assign gt = $signed(b_q) < $signed(a_q);

  assign big_sh = b_q >= DW_V;
  assign amt    = SHW'(b_q % DW_V);

  // Rotates via a doubled word so a zero amount needs no special case.
  assign rotr = DATA_W'({a_q, a_q} >> amt);
  assign rotl = DATA_W'(({a_q, a_q} << amt) >> DATA_W);

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        ovf_d = add_ovf;
        res_d = sum;
        if (add_ovf && sat_q)
          res_d = a_q[DATA_W-1] ? MINV : MAXV;
      end
      OP_SUB: begin
        ovf_d = sub_ovf;
        res_d = diff;
        if (sub_ovf && sat_q)
          res_d = a_q[DATA_W-1] ? MINV : MAXV;
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NOR:  res_d = ~(a_q | b_q);
      OP_SRL:  res_d = big_sh ? '0 : a_q >> b_q;
      OP_ROTR: res_d = rotr;
      OP_NOT:  res_d = ~a_q;
      OP_NAND: res_d = ~(a_q & b_q);
      OP_MAX:  res_d = lt ? b_q : a_q;
      OP_MIN:  res_d = gt ? b_q : a_q;
      OP_ABS: begin
        res_d = a_q[DATA_W-1] ? neg : a_q;
        if (a_q == MINV) begin
          ovf_d = 1'b1;
          res_d = sat_q ? MAXV : a_q;
        end
      end
      OP_SLTS: res_d = {{(DATA_W-1){1'b0}}, lt};
      OP_SLL:  res_d = big_sh ? '0 : a_q << b_q;
      OP_ROTL: res_d = rotl;
    endcase
  end

  // A set on the transfer cycle beats a simultaneous clear.
  assign sticky_d = (s2_v_q && out_ready && ovf_q)
                 || (sticky_q && !ovf_clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      sat_q    <= 1'b0;
      s2_v_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          op_q  <= op_e'(alu_op);
          a_q   <= src1;
          b_q   <= src2;
          sat_q <= sat_en;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          res_q <= res_d;
          ovf_q <= ovf_d;
        end
      end
      sticky_q <= sticky_d;
    end
  end

  assign out_valid    = s2_v_q;
  assign alu_out      = res_q;
  assign alu_overflow = ovf_q;
  assign ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand-written stall,
// sticky-flag and reset sequences for alu_pipe.
module tb_alu_pipe;
  localparam int W = 32;

  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] SUB  = 4'h1;
  localparam logic [3:0] AND_ = 4'h2;
  localparam logic [3:0] OR_  = 4'h3;
  localparam logic [3:0] XOR_ = 4'h4;
  localparam logic [3:0] NOR_ = 4'h5;
  localparam logic [3:0] SRL  = 4'h6;
  localparam logic [3:0] ROTR = 4'h7;
  localparam logic [3:0] NOT_ = 4'h8;
  localparam logic [3:0] NAND = 4'h9;
  localparam logic [3:0] MAX  = 4'hA;
  localparam logic [3:0] MIN  = 4'hB;
  localparam logic [3:0] ABS  = 4'hC;
  localparam logic [3:0] SLTS = 4'hD;
  localparam logic [3:0] SLL  = 4'hE;
  localparam logic [3:0] ROTL = 4'hF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_op = '0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         sat_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         alu_overflow;
  logic         ovf_sticky;
  logic         ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .src1         (src1),
    .src2         (src2),
    .sat_en       (sat_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .ovf_sticky   (ovf_sticky),
    .ovf_clr      (ovf_clr)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sat;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t vt[$];

  function automatic void addv(string n, logic [3:0] op,
                               logic [W-1:0] a, logic [W-1:0] b,
                               logic s, logic [W-1:0] r,
                               logic o);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b;
    v.sat = s; v.res = r; v.ovf = o;
    vt.push_back(v);
  endfunction

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present one op and hold it until accepted; returns on the
  // negedge after the accepting edge with operands scrambled.
  task automatic drive(logic [3:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, logic s);
    int t = 0;
    @(negedge clk);
    alu_op = op; src1 = a; src2 = b; sat_en = s;
    in_valid = 1'b1;
    #1;
    while (!in_ready && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    src1 = $urandom(); src2 = $urandom();
    alu_op = 4'($urandom()); sat_en = 1'b1;
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk); t++;
    end
    chk("out_timeout", out_valid, 1);
  endtask

  task automatic clear_sticky();
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("clr_only", ovf_sticky, 0);
  endtask

  initial begin
    logic [W-1:0] exp_q[4];
    logic [3:0]   b_op[4];
    logic [W-1:0] b_a[4];
    logic [W-1:0] b_b[4];
    logic [W-1:0] held;
    bit hold;
    int sent, got, stalls;

    addv("add_small", ADD, 32'd5, 32'd7, 0, 32'd12, 0);
    addv("add_povf", ADD, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 1);
    addv("add_psat", ADD, 32'h7FFFFFFF, 32'd1, 1, 32'h7FFFFFFF, 1);
    addv("add_nsat", ADD, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1);
    addv("add_nwrap", ADD, 32'h80000000, 32'hFFFFFFFF, 0, 32'h7FFFFFFF, 1);
    addv("sub_nwrap", SUB, 32'h80000000, 32'd1, 0, 32'h7FFFFFFF, 1);
    addv("sub_neg", SUB, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 0);
    addv("sub_psat", SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 1, 32'h7FFFFFFF, 1);
    addv("and", AND_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hF000F000, 0);
    addv("or", OR_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'hFFF0FFF0, 0);
    addv("xor", XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FF00FF0, 0);
    addv("nor", NOR_, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h000F000F, 0);
    addv("srl_32", SRL, 32'hFFFFFFFF, 32'd32, 0, 32'h0, 0);
    addv("srl_31", SRL, 32'h80000000, 32'd31, 0, 32'h1, 0);
    addv("rotr_1", ROTR, 32'h00000001, 32'd1, 0, 32'h80000000, 0);
    addv("rotr_0", ROTR, 32'h12345678, 32'd0, 0, 32'h12345678, 0);
    addv("rotr_36", ROTR, 32'h12345678, 32'd36, 0, 32'h81234567, 0);
    addv("not", NOT_, 32'h12345678, 32'h0, 0, 32'hEDCBA987, 0);
    addv("nand", NAND, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h0FFF0FFF, 0);
    addv("max_m5_3", MAX, 32'hFFFFFFFB, 32'd3, 0, 32'd3, 0);
    addv("max_eq", MAX, 32'd7, 32'd7, 0, 32'd7, 0);
    addv("min_m5_3", MIN, 32'hFFFFFFFB, 32'd3, 0, 32'hFFFFFFFB, 0);
    addv("abs_min_sat", ABS, 32'h80000000, 32'h0, 1, 32'h7FFFFFFF, 1);
    addv("abs_min_wrap", ABS, 32'h80000000, 32'h0, 0, 32'h80000000, 1);
    addv("abs_m10", ABS, 32'hFFFFFFF6, 32'h0, 1, 32'd10, 0);
    addv("slts_m1_1", SLTS, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 0);
    addv("slts_1_m1", SLTS, 32'd1, 32'hFFFFFFFF, 0, 32'd0, 0);
    addv("sll_31", SLL, 32'd1, 32'd31, 0, 32'h80000000, 0);
    addv("sll_40", SLL, 32'hFFFFFFFF, 32'd40, 0, 32'h0, 0);
    addv("rotl_33", ROTL, 32'h80000001, 32'd33, 0, 32'h00000003, 0);
    addv("rotl_4", ROTL, 32'h12345678, 32'd4, 0, 32'h23456781, 0);
    addv("xor_sat", XOR_, 32'h80000000, 32'h80000000, 1, 32'h0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_ovf", alu_overflow, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Vector table
    foreach (vt[i]) begin
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].sat);
      wait_out();
      chk({vt[i].name, "_res"}, alu_out, vt[i].res);
      chk({vt[i].name, "_ovf"}, alu_overflow, vt[i].ovf);
    end

    // Latency and sticky timing for a wrapping overflow
    clear_sticky();
    drive(ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
    chk("lat_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_res", alu_out, 32'h80000000);
    chk("lat_ovf", alu_overflow, 1);
    chk("lat_sticky_pre", ovf_sticky, 0);
    @(negedge clk);
    chk("lat_sticky_set", ovf_sticky, 1);
    chk("lat_drained", out_valid, 0);

    // Clear and overflow transfer on the same edge
    clear_sticky();
    drive(ABS, 32'h80000000, 32'h0, 1'b1);
    wait_out();
    chk("clrset_res", alu_out, 32'h7FFFFFFF);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("clrset_sticky", ovf_sticky, 1);

    // Back-to-back with a 3-cycle output stall
    b_op = '{ADD, ADD, SUB, XOR_};
    b_a  = '{32'd1, 32'd2, 32'd10, 32'd5};
    b_b  = '{32'd1, 32'd2, 32'd3, 32'd3};
    exp_q = '{32'd2, 32'd4, 32'd7, 32'd6};
    sent = 0; got = 0; stalls = 0; hold = 0; held = '0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c < 5);
      if (sent < 4) begin
        alu_op = b_op[sent]; src1 = b_a[sent];
        src2 = b_b[sent]; sat_en = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", alu_out, held);
      end
      chk("b2b_in_ready", in_ready,
          !((sent - got) == 2 && !out_ready));
      if (!in_ready) stalls++;
      if (out_valid && out_ready) begin
        chk("b2b_order", alu_out, exp_q[got]);
        got++;
        hold = 0;
      end else if (out_valid) begin
        held = alu_out;
        hold = 1;
      end else begin
        hold = 0;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("b2b_all_out", got, 4);
    chk("b2b_stalled", stalls > 0, 1);

    // Reset with two ops in flight and sticky set
    out_ready = 1'b1;
    drive(SUB, 32'h80000000, 32'd1, 1'b0);
    wait_out();
    @(negedge clk);
    chk("pre_rst_sticky", ovf_sticky, 1);
    out_ready = 1'b0;
    drive(ADD, 32'd100, 32'd1, 1'b0);
    drive(ADD, 32'd200, 32'd1, 1'b0);
    chk("pre_rst_full", out_valid, 1);
    chk("pre_rst_blocked", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", alu_out, 0);
    chk("mid_rst_ovf", alu_overflow, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", out_valid, 0);
    drive(OR_, 32'h00FF0000, 32'h000000FF, 1'b0);
    wait_out();
    chk("post_rst_res", alu_out, 32'h00FF00FF);
    @(negedge clk);
    chk("post_rst_no_dup", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits (legal range 8..64).
REQ-002 SHALL have parameter SHW, default $clog2(DATA_W), rotate-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-007 SHALL have port alu_op  input  4  operation code, encoding per REQ-016.
REQ-008 SHALL have port src1, src2  input  DATA_W each  operands, two's complement where signed.
REQ-009 SHALL have port sat_en  input  1  saturate ADD/SUB/ABS on overflow instead of wrapping.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result when high with out_valid.
REQ-012 SHALL have port alu_out  output  DATA_W  result.
REQ-013 SHALL have port alu_overflow  output  1  signed overflow of the result in flight.
REQ-014 SHALL have port ovf_sticky  output  1  latched overflow status; ovf_clr  input  1  clears it.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 registers op/operands/sat_en, S2 registers result/overflow; unstalled latency 2 cycles, throughput 1 op/cycle.
REQ-016 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SRL, 7 ROTR, 8 NOT(src1), 9 NAND, A MAX, B MIN, C ABS(src1), D SLTS, E SLL, F ROTL.
REQ-017 ADD/SUB: DATA_W-bit wrap result; overflow = operand signs (src2 inverted for SUB) equal and result sign differs.
REQ-018 sat_en=1 and ADD/SUB overflow: result SHALL clamp to 2^(DATA_W-1)-1 (positive overflow) or -2^(DATA_W-1) (negative); alu_overflow still 1.
REQ-019 ABS: negative src1 -> negated; src1 = -2^(DATA_W-1) -> overflow=1, result unchanged (sat_en=0) or 2^(DATA_W-1)-1 (sat_en=1).
REQ-020 SRL/SLL: logical shift by full unsigned src2; src2 >= DATA_W yields 0.
REQ-021 ROTR/ROTL: rotate by src2 mod DATA_W; amount 0 returns src1.
REQ-022 MAX/MIN: signed compare, equal operands return src1; SLTS: 1 if signed src1 < src2 else 0.
REQ-023 alu_overflow SHALL be 0 for every op other than ADD, SUB, ABS.
REQ-024 Handshake: transfer on valid&ready; S2 advances when !out_valid | out_ready; S1 advances when S1 empty or S2 advances; in_ready = !S1_valid | S1 advances (no combinational path from in_valid to in_ready).
REQ-025 While out_valid & !out_ready, alu_out/alu_overflow/out_valid SHALL hold stable; no result dropped or duplicated; order preserved.
REQ-026 Pipeline full with out_ready=0: in_ready SHALL be 0; at most 2 ops in flight.
REQ-027 ovf_sticky SHALL set on the cycle a result with alu_overflow=1 transfers out; ovf_clr clears it; simultaneous set and clear -> set wins (ovf_sticky=1).
REQ-028 Inputs while in_ready=0 SHALL be ignored; operands need not be held once accepted.

Reset
REQ-029 rst_n=0 at a clock edge SHALL empty both stages: out_valid=0, alu_out=0, alu_overflow=0, ovf_sticky=0; in-flight ops discarded.
REQ-030 During reset in_ready SHALL be 0; first acceptance on the first edge with rst_n=1.
REQ-031 Reset asserted mid-stall SHALL override hold rule REQ-025.

Verification
REQ-032 DATA_W=32, ADD 0x7FFFFFFF+1, sat_en=0, out_ready=1 -> 2 cycles later alu_out=0x80000000, alu_overflow=1, ovf_sticky=1 next cycle.
REQ-033 Same with sat_en=1 -> alu_out=0x7FFFFFFF, overflow=1; ABS 0x80000000 sat_en=1 -> 0x7FFFFFFF, overflow=1.
REQ-034 ROTL 0x80000001 by 33 -> 0x00000003; SRL 0xFFFFFFFF by 32 -> 0; SLTS -1,1 -> 1; MAX -5,3 -> 3.
REQ-035 Back-to-back 4 ops, out_ready=0 from cycle 2 for 3 cycles -> in_ready=0 after 2 accepts, alu_out stable, all 4 results emerge in order once out_ready=1.
REQ-036 rst_n=0 with 2 ops in flight -> next cycle out_valid=0, ovf_sticky=0; ovf_clr and overflow transfer same cycle -> ovf_sticky=1.
